shifter_pipe: RTL
=================

Name: shifter_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle ALU shifter.
- Shifts a WIDTH-bit operand by a log2(WIDTH)-bit amount. Modes: SRL, SLL, SRA, ROR, ROL.
- The log2(WIDTH) barrel levels are spread over STAGES register stages. A valid/ready handshake on both sides provides backpressure.
- Sits between the decode/issue logic and writeback. It carries an opaque tag (e.g. rd index) alongside the data.

Parameters:
- WIDTH, 32: operand/result width; must be a power of 2, at least 8.
- STAGES, 2: pipeline register stages, 1..log2(WIDTH). Barrel levels are split evenly, with the earlier stages taking the extra levels.
- TAG_W, 5: width of the sideband tag passed through unchanged.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream request valid
- in_ready  out  1  block can accept a request this cycle
- in_a  in  WIDTH  value to shift
- in_shamt  in  $clog2(WIDTH)  shift amount
- in_op  in  3  mode: 000 SRL, 001 SLL, 010 SRA, 011 ROR, 100 ROL, 101-111 illegal
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_r  out  WIDTH  shifted result
- out_tag  out  TAG_W  tag of this result
- out_err  out  1  request used an illegal op

Behaviour:
- Reset (async, rst_n=0): all stage valid bits = 0; out_valid = 0, out_r = 0, out_tag = 0, out_err = 0; in_ready = 1 once rst_n deasserts.
- Accept: a transfer happens when in_valid && in_ready on a rising edge. Output handshake completes when out_valid && out_ready.
- Stall rule: stall = out_valid && !out_ready. in_ready = !stall (combinational). While stalled, every stage register, including out_*, holds.
- Latency: exactly STAGES cycles from acceptance to out_valid with no stall. Throughput is 1 result/cycle.
- Bubbles: a stage with valid=0 advances on the next edge even under partial occupancy. Bubbles are not compressed, because stall is global.
- Barrel levels: level k shifts by 2^k when shamt[k]=1.
  - SRL: zero-fill from the MSB side.
  - SLL: zero-fill from the LSB side.
  - SRA: fill with in_a[WIDTH-1], captured at acceptance.
  - ROR/ROL: bits wrap around.
- Pipeline contents: op, remaining shamt bits, tag and err travel with the data.
- Shift amount: shamt == 0 returns in_a unchanged for every legal op. The maximum is shamt = WIDTH-1; there is no modulo beyond the port width.
- Illegal op: out_r = 0, out_err = 1, latency unchanged, tag still delivered.
- Simultaneous accept and drain: an accept and an output drain in the same cycle are both legal. Full throughput holds with out_ready held at 1.
- in_valid while stalled: ignored (in_ready = 0). The upstream must hold its data stable until accepted.
- Reset mid-operation: all in-flight requests are discarded and no out_valid is produced afterwards for them.
- Combinational paths: none from in_* to out_*. The only combinational path is out_ready -> in_ready.

Decomposition:
- Shared defines header (alongside the existing ALU defines) holds:
  - op encodings SHF_SRL=3'b000, SHF_SLL=3'b001, SHF_SRA=3'b010, SHF_ROR=3'b011, SHF_ROL=3'b100;
  - the default WIDTH.
- SRL/SLL/SRA codes keep the old 2-bit type values, zero-extended.
- Sub-module shifter_pipe_level: one combinational barrel level, with a parameter for the shift distance 2^k and inputs data, bit_en and op. It is instantiated log2(WIDTH) times via generate.
- Stage registers are built in the top level.

Test Plan:
- SRA 32'h8000_0000 by 31, tag 7, out_ready=1 -> after STAGES cycles: out_r=32'hFFFF_FFFF, out_tag=7, out_err=0.
- Back-to-back stream, one request per cycle, out_ready=1:
  - inputs: SLL 32'h1 by 4; SRL 32'hF0 by 4; ROR 32'h1 by 1; ROL 32'h8000_0000 by 1;
  - expected outputs, on consecutive cycles: 32'h10, 32'hF, 32'h8000_0000, 32'h1.
- Backpressure: fill the pipe, drop out_ready for 3 cycles -> in_ready=0, and out_r/out_tag are held stable through the stall. Raising out_ready drains all results in order with none lost or duplicated.
- Illegal op 3'b110 with in_a=32'hDEAD_BEEF -> out_r=0, out_err=1, tag preserved. The next legal request completes normally.
- Assert rst_n=0 asynchronously, mid-cycle, with 2 requests in flight -> out_valid=0 immediately and no stale results after release. The first new request returns with STAGES latency.
- Parameter sweep WIDTH=8/16/64, STAGES=1..log2(WIDTH): random ops and shamts are compared against a reference model. Include shamt=0 and shamt=WIDTH-1 for every op.

Source files
------------

// File: rtl/shifter_pipe_pkg.sv
// Shared shifter definitions: op encodings, default width and
// helpers that split the barrel levels across pipeline stages.
package shifter_pipe_pkg;

    localparam int SHF_WIDTH = 32;

    // SRL/SLL/SRA keep the legacy 2-bit ALU shift codes, zero-extended.
    typedef enum logic [2:0] {
        SHF_SRL = 3'b000,
        SHF_SLL = 3'b001,
        SHF_SRA = 3'b010,
        SHF_ROR = 3'b011,
        SHF_ROL = 3'b100
    } shf_op_e;

    function automatic logic shf_legal(input logic [2:0] op);
        return op <= SHF_ROL;
    endfunction

    // Levels handled by stage s; earlier stages absorb the remainder.
    function automatic int shf_lvl_cnt(input int s, input int levels,
                                       input int stages);
        return levels / stages + ((s < levels % stages) ? 1 : 0);
    endfunction

    // Index of the first level handled by stage s.
    function automatic int shf_lvl_lo(input int s, input int levels,
                                      input int stages);
        return s * (levels / stages)
             + ((s < levels % stages) ? s : levels % stages);
    endfunction

endpackage

// File: rtl/shifter_pipe_level.sv
// One combinational barrel level: shifts/rotates data by DIST when
// bit_en is set. Ports: data, bit_en, op, sign (SRA fill) -> result.
module shifter_pipe_level
    import shifter_pipe_pkg::*;
#(
    parameter int WIDTH = SHF_WIDTH,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             bit_en,
    input  logic [2:0]       op,
    input  logic             sign,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = data;
        if (bit_en) begin
            case (op)
                SHF_SRL: result = {{DIST{1'b0}}, data[WIDTH-1:DIST]};
                SHF_SLL: result = {data[WIDTH-DIST-1:0], {DIST{1'b0}}};
                SHF_SRA: result = {{DIST{sign}}, data[WIDTH-1:DIST]};
                SHF_ROR: result = {data[DIST-1:0], data[WIDTH-1:DIST]};
                SHF_ROL: result = {data[WIDTH-DIST-1:0],
                                   data[WIDTH-1:WIDTH-DIST]};
                default: result = data;
            endcase
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SRL/SLL/SRA/ROR/ROL) with valid/ready on
// both sides. Ports: in_valid/in_ready/in_a/in_shamt/in_op/in_tag ->
// out_valid/out_ready/out_r/out_tag/out_err; clk, async rst_n.
module shifter_pipe
    import shifter_pipe_pkg::*;
#(
    parameter int WIDTH  = SHF_WIDTH,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [2:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_r,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_err
);

    localparam int LEVELS = $clog2(WIDTH);

    // data must stay the last field: stages splice new data below it.
    typedef struct packed {
        logic              valid;
        logic              err;
        logic              sign;
        logic [2:0]        op;
        logic [LEVELS-1:0] shamt;
        logic [TAG_W-1:0]  tag;
        logic [WIDTH-1:0]  data;
    } stage_t;

    localparam int SB = $bits(stage_t);

    stage_t head;
    stage_t nxt [STAGES];
    stage_t q   [STAGES];
    logic   stall;

    assign stall    = q[STAGES-1].valid && !out_ready;
    assign in_ready = !stall;

    // Illegal ops enter as zero data, so every level leaves them zero.
    always_comb begin
        head       = '0;
        head.valid = in_valid;
        head.err   = !shf_legal(in_op);
        head.sign  = in_a[WIDTH-1];
        head.op    = in_op;
        head.shamt = in_shamt;
        head.tag   = in_tag;
        head.data  = shf_legal(in_op) ? in_a : '0;
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = shf_lvl_lo(s, LEVELS, STAGES);
        localparam int N  = shf_lvl_cnt(s, LEVELS, STAGES);

        stage_t           src;
        logic [WIDTH-1:0] chain [N+1];

        if (s == 0) begin : g_head
            assign src = head;
        end else begin : g_body
            assign src = q[s-1];
        end

        assign chain[0] = src.data;

        for (genvar j = 0; j < N; j++) begin : g_lvl
            shifter_pipe_level #(
                .WIDTH (WIDTH),
                .DIST  (1 << (LO + j))
            ) u_lvl (
                .data   (chain[j]),
                .bit_en (src.shamt[LO+j]),
                .op     (src.op),
                .sign   (src.sign),
                .result (chain[j+1])
            );
        end

        assign nxt[s] = {src[SB-1:WIDTH], chain[N]};
    end

    // Stall is global: all stages, bubbles included, move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                q[s] <= '0;
            end
        end else if (!stall) begin
            for (int s = 0; s < STAGES; s++) begin
                q[s] <= nxt[s];
            end
        end
    end

    assign out_valid = q[STAGES-1].valid;
    assign out_r     = q[STAGES-1].data;
    assign out_tag   = q[STAGES-1].tag;
    assign out_err   = q[STAGES-1].err;

endmodule
